// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin write arbiter.
//   state_t / ST_IDLE / ST_OWNED : arbiter FSM encoding
//   owner_w(n)                   : width of an index into n requesters (at least 1)
package dff_arb_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_OWNED = 1'b1;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_if.sv
// Requester-side bundle of the write arbiter.
//   req     : per-requester write request (level)
//   lock    : per-requester burst-ownership request, only meaningful with req
//   wdata   : requester i data at [i*WIDTH +: WIDTH]
//   gnt     : one-hot, gnt[i] means wdata[i] was captured at the preceding edge
//   q       : shared register contents
//   q_valid : sticky, set by the first write after reset
//   owner   : index of the last writer
//   state   : arbiter FSM state, exposed for observation
//
// Handshake: a requester raises req[i] with wdata[i] and keeps both stable
// until it sees gnt[i]=1. That grant cycle is the acceptance of the data;
// the requester then either drops req[i] or presents its next word. There is
// no other back-pressure.
interface dff_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  import dff_arb_pkg::*;

  localparam int OW = owner_w(N);

  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic               q_valid;
  logic [OW-1:0]      owner;
  state_t             state;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_valid, owner, state
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_valid, owner, state
  );

endinterface

// File: rtl/dff_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   masked : eligible requesters
//   ptr    : index where the search starts
//   any    : at least one eligible requester
//   idx    : first eligible index at or after ptr, wrapping at N
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          masked,
  input  logic [owner_w(N)-1:0] ptr,
  output logic                  any,
  output logic [owner_w(N)-1:0] idx
);

  localparam int OW = owner_w(N);

  int cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && masked[cand]) begin
        any = 1'b1;
        idx = OW'(cand);
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// At most one requester is written per edge. A winner that asserts lock keeps
// ownership for up to MAX_HOLD back-to-back writes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester bundle (slave side), see dff_write_arbiter_if
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  dff_write_arbiter_if.slave bus
);

  localparam int OW = owner_w(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t           state, state_n;
  logic [N-1:0]     gnt_q, gnt_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             valid_r, valid_n;
  logic [OW-1:0]    owner_r, owner_n;
  logic [OW-1:0]    ptr, ptr_n;
  logic [HW-1:0]    hold_cnt, hold_n;

  logic [N-1:0]     masked;
  logic             any;
  logic [OW-1:0]    win;

  // Last edge's winner sits out one edge, so an unlocked requester can
  // never write twice in a row.
  assign masked = bus.req & ~gnt_q;

  rr_pick #(.N(N)) u_pick (
    .masked (masked),
    .ptr    (ptr),
    .any    (any),
    .idx    (win)
  );

  // State register: every piece of arbiter state lives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      q_r      <= '0;
      valid_r  <= 1'b0;
      owner_r  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_q    <= gnt_n;
      q_r      <= q_n;
      valid_r  <= valid_n;
      owner_r  <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    gnt_n   = '0;
    q_n     = q_r;
    valid_n = valid_r;
    owner_n = owner_r;
    ptr_n   = ptr;
    hold_n  = hold_cnt;

    case (state)
      ST_IDLE: begin
        if (any) begin
          q_n     = bus.wdata[int'(win)*WIDTH +: WIDTH];
          gnt_n   = {{(N-1){1'b0}}, 1'b1} << win;
          owner_n = win;
          valid_n = 1'b1;
          ptr_n   = (int'(win) == N - 1) ? '0 : win + 1'b1;
          hold_n  = HW'(1);
          state_n = (bus.lock[win] && (MAX_HOLD > 1)) ? ST_OWNED : ST_IDLE;
        end
      end

      ST_OWNED: begin
        // Only the owner is looked at; ptr stays put so the rotation resumes
        // after the burst exactly where the owner's win left it.
        if (bus.req[owner_r]) begin
          q_n     = bus.wdata[int'(owner_r)*WIDTH +: WIDTH];
          gnt_n   = {{(N-1){1'b0}}, 1'b1} << owner_r;
          hold_n  = hold_cnt + 1'b1;
          state_n = (bus.lock[owner_r] && ((int'(hold_cnt) + 1) < MAX_HOLD))
                    ? ST_OWNED : ST_IDLE;
        end else begin
          // Owner walked away: one idle edge before arbitration resumes.
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are straight register copies; no input reaches an output
  // combinationally.
  always_comb begin
    bus.gnt     = gnt_q;
    bus.q       = q_r;
    bus.q_valid = valid_r;
    bus.owner   = owner_r;
    bus.state   = state;
  end

endmodule

// File: tb/tb_dff_write_arbiter.sv
module tb_dff_write_arbiter;

  localparam int N        = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int OW       = 2;
  localparam int EW       = N + WIDTH + 1 + OW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dff_write_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  dff_write_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int vectors;
  int miscompares;
  logic [EW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Described by the rules: who was served last edge, whose burst is open,
  // how many writes it has had, and where the next search starts.
  logic [WIDTH-1:0] m_q;
  bit               m_valid;
  int               m_owner;
  int               m_ptr;
  int               m_last;
  bit               m_burst;
  int               m_writes;

  task automatic model_reset();
    m_q      = '0;
    m_valid  = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_last   = -1;
    m_burst  = 1'b0;
    m_writes = 0;
  endtask

  function automatic logic [EW-1:0] model_step(input logic [N-1:0] r,
                                               input logic [N-1:0] l,
                                               input logic [N*WIDTH-1:0] d);
    int w;
    int c;
    logic [N-1:0] g;
    w = -1;
    if (m_burst) begin
      if (r[m_owner]) begin
        w        = m_owner;
        m_writes = m_writes + 1;
        m_burst  = l[w] && (m_writes < MAX_HOLD);
      end else begin
        m_burst = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && r[c] && c != m_last) w = c;
      end
      if (w >= 0) begin
        m_owner  = w;
        m_ptr    = (w + 1) % N;
        m_writes = 1;
        m_burst  = l[w] && (MAX_HOLD > 1);
      end
    end
    if (w >= 0) begin
      m_q     = d[w*WIDTH +: WIDTH];
      m_valid = 1'b1;
    end
    m_last = w;
    g = (w >= 0) ? (N'(1) << w) : '0;
    return {g, m_q, m_valid, OW'(m_owner)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    bus.wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic compare_outputs(input string tag);
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check_eq({tag, ".gnt"},     32'(bus.gnt),     32'(e[EW-1 -: N]));
    check_eq({tag, ".q"},       32'(bus.q),       32'(e[OW+1 +: WIDTH]));
    check_eq({tag, ".q_valid"}, 32'(bus.q_valid), 32'(e[OW]));
    check_eq({tag, ".owner"},   32'(bus.owner),   32'(e[OW-1:0]));
  endtask

  // One clock edge with the currently driven inputs, checked against the model.
  task automatic step(input string tag);
    exp_q.push_back(model_step(bus.req, bus.lock, bus.wdata));
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, ".gnt"},     32'(bus.gnt),     32'(0));
    check_eq({tag, ".q"},       32'(bus.q),       32'(0));
    check_eq({tag, ".q_valid"}, 32'(bus.q_valid), 32'(0));
    check_eq({tag, ".owner"},   32'(bus.owner),   32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start a burst for requester 1 with ptr already at 1.
  task automatic setup_owner1();
    bus.req  = 4'b0001;
    bus.lock = 4'b0000;
    set_data(0, 8'h5A);
    step("pre");
    check_eq("pre.gnt", 32'(bus.gnt), 32'h1);
    bus.req  = 4'b0011;
    bus.lock = 4'b0010;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n     = 1'b1;
    bus.req   = 4'b1111;
    bus.lock  = '0;
    bus.wdata = '0;
    for (int i = 0; i < N; i++) set_data(i, WIDTH'(8'h10 + i));

    // Reset with all requests pending, before any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst.gnt",     32'(bus.gnt),     32'(0));
    check_eq("rst.q",       32'(bus.q),       32'(0));
    check_eq("rst.q_valid", 32'(bus.q_valid), 32'(0));
    check_eq("rst.owner",   32'(bus.owner),   32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fair rotation: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      step("rot");
      check_eq("rot.gnt_k", 32'(bus.gnt), 32'(1 << (k % 4)));
      check_eq("rot.q_k",   32'(bus.q),   32'(8'h10 + (k % 4)));
    end

    // Lone unlocked requester writes every other cycle.
    bus.req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      set_data(2, WIDTH'(8'h60 + k));
      step("lone");
      check_eq("lone.gnt_k", 32'(bus.gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
    end

    // Locked burst of exactly MAX_HOLD writes, then requester 0.
    async_reset("rst_a");
    setup_owner1();
    for (int k = 0; k < MAX_HOLD; k++) begin
      set_data(1, WIDTH'(8'hA0 + k));
      step("burst");
      check_eq("burst.gnt_k", 32'(bus.gnt), 32'h2);
      check_eq("burst.q_k",   32'(bus.q),   32'(8'hA0 + k));
    end
    step("burst_end");
    check_eq("burst_end.gnt", 32'(bus.gnt), 32'h1);
    check_eq("burst_end.q",   32'(bus.q),   32'h5A);

    // Early release: bubble, then the waiting requester 0.
    async_reset("rst_b");
    setup_owner1();
    for (int k = 0; k < 2; k++) begin
      set_data(1, WIDTH'(8'hB0 + k));
      step("early");
    end
    bus.req = 4'b0001;
    step("bubble");
    check_eq("bubble.gnt", 32'(bus.gnt), 32'h0);
    step("after_bubble");
    check_eq("after_bubble.gnt", 32'(bus.gnt), 32'h1);

    // Reset mid-burst at hold_cnt=2; arbitration restarts from requester 0.
    async_reset("rst_c");
    setup_owner1();
    for (int k = 0; k < 2; k++) begin
      set_data(1, WIDTH'(8'hC0 + k));
      step("mid");
    end
    async_reset("rst_mid");
    bus.req  = 4'b1111;
    bus.lock = 4'b0000;
    step("restart");
    check_eq("restart.gnt", 32'(bus.gnt), 32'h1);
    check_eq("restart.q",   32'(bus.q),   32'h5A);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.req  = N'($urandom_range(0, (1 << N) - 1));
      bus.lock = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 1) == 1) bus.wdata = (N*WIDTH)'($urandom);
      if ($urandom_range(0, 60) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
